mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Single-owner arbiter that shares the synchronous-read system memory between the cpu6502 core and one DMA requester. It also decodes the memory-mapped I/O port. It sits between the CPU's `address_next`/`write_next`/`data_o_next`/`data_i`/`ready` pins and the memory's `we`/`addr_w`/`di`/`do` pins. The CPU is stalled through `cpu_ready` while DMA owns the bus. DMA tenure is bounded, so the CPU is never starved.

## Interface
- `DMA_BURST_MAX`, 4: maximum consecutive DMA accesses per tenure; legal range 1..15.
- `IO_ADDR`, 16'hbffc: CPU address decoded as the I/O port instead of memory.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_address_next`  in  16  CPU next-cycle address.
- `cpu_write_next`  in  1  CPU next-cycle write strobe.
- `cpu_data_o_next`  in  8  CPU write data.
- `cpu_data_i`  out  8  read data to CPU.
- `cpu_ready`  out  1  CPU advance enable.
- `dma_req`  in  1  DMA access request; hold high while accesses are pending.
- `dma_write`  in  1  DMA access is a write.
- `dma_addr`  in  16  DMA address.
- `dma_wdata`  in  8  DMA write data.
- `dma_ack`  out  1  the current-cycle DMA access is performed.
- `dma_rdata`  out  8  DMA read data.
- `dma_rvalid`  out  1  `dma_rdata` is valid.
- `io_we`  out  1  one-cycle CPU write pulse to the I/O port.
- `io_wdata`  out  8  I/O write data (equals `cpu_data_o_next`).
- `io_rdata`  in  8  I/O port read value.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  16  memory address (to `addr_w`).
- `mem_di`  out  8  memory write data.
- `mem_do`  in  8  memory read data; valid the cycle after the address is presented.

## Operation
- **States:** `owner` ∈ {CPU, DMA}; `burst_cnt` is 4 bits.
- **CPU state:**
  - Memory pins are muxed from the CPU pins; `cpu_ready`=1.
  - If `cpu_address_next`==`IO_ADDR`: `mem_we`=0 and `io_we`=`cpu_write_next`.
  - Otherwise `mem_we`=`cpu_write_next`.
  - At a rising edge with `dma_req`=1: go to DMA, `burst_cnt`←0. The CPU access of that cycle still completes.
- **DMA state:**
  - Memory pins are muxed from the DMA pins; `cpu_ready`=0; `io_we`=0.
  - `dma_ack`=`dma_req`; `mem_we`=`dma_ack & dma_write`. DMA never decodes `IO_ADDR`; those accesses go to memory.
  - CPU address and write inputs are ignored, so no CPU write is repeated during a stall.
  - At a rising edge, if `dma_req`=0, or `dma_ack`=1 and `burst_cnt`==`DMA_BURST_MAX`-1: go to CPU.
  - Otherwise, if `dma_ack`=1, `burst_cnt` increments.
- **Fairness:** the DMA→CPU→DMA minimum is one CPU cycle, because a request is only sampled in the CPU state.
- **CPU read path:**
  - Register `sel` records the read source for `cpu_data_i`. Values: MEM when last cycle was a CPU non-IO cycle, IO when it was a CPU IO cycle, HOLD otherwise.
  - `cpu_data_i` = `mem_do` / registered `io_rdata` / `hold_q`, according to `sel`.
  - `hold_q` captures `cpu_data_i` every cycle in which `sel`≠HOLD. The CPU therefore sees the data for its last address across any stall, even if DMA overwrites that location.
- **DMA read path:** `dma_rvalid` is registered and equals 1 the cycle after a DMA read ack; `dma_rdata`=`mem_do`.
- **Reset** (asynchronous, wins over everything):
  - `owner`=CPU, `burst_cnt`=0, `sel`=HOLD, `hold_q`=8'h00, `dma_rvalid`=0.
  - While `reset`=1: `mem_we`=0, `io_we`=0, `dma_ack`=0, `cpu_ready`=1, `cpu_data_i`=8'h00.
  - A reset during a burst abandons the burst; no partial-tenure state survives.

## Timing
- **Cycle t, CPU state:** address driven combinationally. Read data reaches `cpu_data_i` at t+1; a write takes effect at the end of t.
- **DMA grant:** `dma_req` rising during cycle t (CPU) → `cpu_ready`=0 and `dma_ack`=1 in cycle t+1.
- **DMA read latency:** ack at t → `dma_rvalid`=1 with data at t+1 (`dma_rvalid` may be high in the first CPU cycle after a tenure).
- **Full burst:** `DMA_BURST_MAX` ack cycles, then at least one cycle with `cpu_ready`=1.
- **Request dropped mid-tenure:** costs one idle DMA cycle (`cpu_ready`=0, no ack) before the CPU resumes.
- **Combinational paths:** `cpu_ready`, `dma_ack` and the memory pins are combinational from `owner` and the inputs only. No combinational path exists from `mem_do` to any memory pin.

## Test plan
- **No DMA:** reset for 14 cycles, then run → `cpu_ready`=1 every cycle, `mem_addr`==`cpu_address_next`, `dma_ack`=0.
- **Bounded burst:** `DMA_BURST_MAX`=4, `dma_req` held for 6 writes to 0x4000..0x4005 → acks in 4 cycles, then 1 CPU cycle, then 2 acks. Memory holds all 6 bytes; the CPU issues no write during the stall.
- **DMA read:** memory[0x1234]=0x5a, one DMA read → `dma_rvalid`=1 with `dma_rdata`=0x5a exactly one cycle after `dma_ack`.
- **Stall hold:** CPU reads 0x0200 (=0xa9); DMA takes the next cycle and writes 0x00 to 0x0200 → `cpu_data_i`=0xa9 throughout the stall and on resume.
- **I/O decode:** CPU writes 0x3c to 0xbffc → `io_we`=1, `io_wdata`=0x3c, `mem_we`=0. Then a CPU read of 0xbffc with `io_rdata`=0x81 → `cpu_data_i`=0x81; memory[0xbffc] is unchanged.
- **Reset mid-burst:** assert `reset` on the 2nd ack → `dma_ack`=0 and `cpu_ready`=1 immediately. After release `owner`=CPU and a new request gets a full 4-access tenure.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares a synchronous-read memory between the CPU and one DMA requester,
// decodes the single I/O port address, and stalls the CPU while DMA owns the bus.
module mem_bus_arbiter #(
    parameter int          DMA_BURST_MAX = 4,
    parameter logic [15:0] IO_ADDR       = 16'hbffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_address_next,
    input  logic        cpu_write_next,
    input  logic [7:0]  cpu_data_o_next,
    output logic [7:0]  cpu_data_i,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic        dma_write,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,
    output logic        io_we,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_di,
    input  logic [7:0]  mem_do
);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_IO   = 2'd2
    } sel_e;

    localparam logic [3:0] BURST_LAST = 4'(DMA_BURST_MAX - 1);

    owner_e      owner_q, owner_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    sel_e        sel_q, sel_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  io_rdata_q;
    logic        dma_rvalid_q, dma_rvalid_d;
    logic        cpu_is_io_s;

    assign cpu_is_io_s = (cpu_address_next == IO_ADDR);
    assign io_wdata    = cpu_data_o_next;
    assign dma_rdata   = mem_do;
    assign dma_rvalid  = dma_rvalid_q;

    // Bus mux: memory and I/O strobes follow the current owner; reset forces everything quiet.
    always_comb begin
        mem_addr  = cpu_address_next;
        mem_di    = cpu_data_o_next;
        mem_we    = 1'b0;
        io_we     = 1'b0;
        dma_ack   = 1'b0;
        cpu_ready = 1'b1;
        if (reset) begin
            mem_we = 1'b0;
        end else begin
            case (owner_q)
                OWN_DMA: begin
                    mem_addr  = dma_addr;
                    mem_di    = dma_wdata;
                    dma_ack   = dma_req;
                    mem_we    = dma_req & dma_write;
                    cpu_ready = 1'b0;
                end
                OWN_CPU: begin
                    if (cpu_is_io_s) begin
                        io_we = cpu_write_next;
                    end else begin
                        mem_we = cpu_write_next;
                    end
                end
                default: begin
                    cpu_ready = 1'b1;
                end
            endcase
        end
    end

    // CPU read-data source selected by what the previous cycle did.
    always_comb begin
        cpu_data_i = 8'h00;
        if (reset) begin
            cpu_data_i = 8'h00;
        end else begin
            case (sel_q)
                SEL_MEM:  cpu_data_i = mem_do;
                SEL_IO:   cpu_data_i = io_rdata_q;
                default:  cpu_data_i = hold_q;
            endcase
        end
    end

    // Ownership, burst accounting and read-path bookkeeping for the next cycle.
    always_comb begin
        owner_d      = owner_q;
        burst_cnt_d  = burst_cnt_q;
        sel_d        = SEL_HOLD;
        dma_rvalid_d = 1'b0;
        hold_d       = (sel_q != SEL_HOLD) ? cpu_data_i : hold_q;
        case (owner_q)
            OWN_CPU: begin
                sel_d = cpu_is_io_s ? SEL_IO : SEL_MEM;
                if (dma_req) begin
                    owner_d     = OWN_DMA;
                    burst_cnt_d = 4'd0;
                end else begin
                    owner_d = OWN_CPU;
                end
            end
            OWN_DMA: begin
                dma_rvalid_d = dma_req & ~dma_write;
                // The tenure ends on a dropped request or after the last allowed ack.
                if (!dma_req) begin
                    owner_d = OWN_CPU;
                end else if (burst_cnt_q == BURST_LAST) begin
                    owner_d = OWN_CPU;
                end else begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
            end
            default: begin
                owner_d = OWN_CPU;
            end
        endcase
    end

    // State registers; reset abandons any tenure in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= OWN_CPU;
            burst_cnt_q  <= 4'd0;
            sel_q        <= SEL_HOLD;
            hold_q       <= 8'h00;
            io_rdata_q   <= 8'h00;
            dma_rvalid_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            burst_cnt_q  <= burst_cnt_d;
            sel_q        <= sel_d;
            hold_q       <= hold_d;
            io_rdata_q   <= io_rdata;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
// run compared against a rule-level ownership and memory model.
module tb_mem_bus_arbiter;

    localparam logic [15:0] IO_ADDR   = 16'hbffc;
    localparam int          BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_address_next;
    logic        cpu_write_next;
    logic [7:0]  cpu_data_o_next;
    logic [7:0]  cpu_data_i;
    logic        cpu_ready;
    logic        dma_req;
    logic        dma_write;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        dma_rvalid;
    logic        io_we;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_di;
    logic [7:0]  mem_do;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_arr [0:65535];

    always #5 clk = ~clk;

    // Synchronous-read memory: old contents are returned on a same-address write.
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr] <= mem_di;
        mem_do <= mem_arr[mem_addr];
    end

    mem_bus_arbiter #(
        .DMA_BURST_MAX(BURST_MAX),
        .IO_ADDR(IO_ADDR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpu_address_next(cpu_address_next),
        .cpu_write_next(cpu_write_next),
        .cpu_data_o_next(cpu_data_o_next),
        .cpu_data_i(cpu_data_i),
        .cpu_ready(cpu_ready),
        .dma_req(dma_req),
        .dma_write(dma_write),
        .dma_addr(dma_addr),
        .dma_wdata(dma_wdata),
        .dma_ack(dma_ack),
        .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid),
        .io_we(io_we),
        .io_wdata(io_wdata),
        .io_rdata(io_rdata),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_di(mem_di),
        .mem_do(mem_do)
    );

    task automatic idle();
        cpu_address_next = 16'h0000;
        cpu_write_next   = 1'b0;
        cpu_data_o_next  = 8'h00;
        dma_req          = 1'b0;
        dma_write        = 1'b0;
        dma_addr         = 16'h0000;
        dma_wdata        = 8'h00;
        io_rdata         = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        idle();
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        cpu_address_next = IO_ADDR;
        cpu_write_next   = 1'b1;
        dma_req          = 1'b1;
        dma_write        = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            #1;
            if (i == 7) cpu_address_next = 16'h0123;
            #1;
            checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we cyc=%0d got=%b exp=0", i, mem_we); end
            checks++; if (io_we !== 1'b0) begin failures++; $display("FAIL reset_io_we cyc=%0d got=%b exp=0", i, io_we); end
            checks++; if (dma_ack !== 1'b0) begin failures++; $display("FAIL reset_dma_ack cyc=%0d got=%b exp=0", i, dma_ack); end
            checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL reset_cpu_ready cyc=%0d got=%b exp=1", i, cpu_ready); end
            checks++; if (cpu_data_i !== 8'h00) begin failures++; $display("FAIL reset_cpu_data cyc=%0d got=%h exp=00", i, cpu_data_i); end
            checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid cyc=%0d got=%b exp=0", i, dma_rvalid); end
        end
        reset = 1'b0;
        idle();
        #1;
        checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", cpu_ready); end
        step();
    endtask

    task automatic test_no_dma();
        for (int i = 0; i < 20; i++) begin
            cpu_address_next = 16'h0100 + 16'($urandom_range(0, 255));
            cpu_write_next   = 1'($urandom_range(0, 1));
            cpu_data_o_next  = 8'($urandom);
            dma_req          = 1'b0;
            #1;
            checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL nodma_ready cyc=%0d got=%b exp=1", i, cpu_ready); end
            checks++; if (mem_addr !== cpu_address_next) begin failures++; $display("FAIL nodma_addr cyc=%0d got=%h exp=%h", i, mem_addr, cpu_address_next); end
            checks++; if (dma_ack !== 1'b0) begin failures++; $display("FAIL nodma_ack cyc=%0d got=%b exp=0", i, dma_ack); end
            checks++; if (mem_we !== cpu_write_next) begin failures++; $display("FAIL nodma_we cyc=%0d got=%b exp=%b", i, mem_we, cpu_write_next); end
            step();
        end
        settle();
    endtask

    task automatic test_burst();
        int k;
        logic exp_ack, exp_ready;
        k = 0;
        cpu_address_next = 16'h4100;
        cpu_write_next   = 1'b1;
        cpu_data_o_next  = 8'hee;
        dma_req   = 1'b1;
        dma_write = 1'b1;
        dma_addr  = 16'h4000;
        dma_wdata = 8'h10;
        #1;
        checks++; if (dma_ack !== 1'b0 || cpu_ready !== 1'b1) begin failures++; $display("FAIL burst_grant_cycle got ack=%b ready=%b exp ack=0 ready=1", dma_ack, cpu_ready); end
        step();
        for (int i = 0; i < 9; i++) begin
            dma_addr  = 16'h4000 + 16'(k);
            dma_wdata = 8'h10 + 8'(k);
            dma_req   = (k < 6);
            exp_ack   = (i != 4) && (i <= 6);
            exp_ready = (i == 4) || (i == 8);
            #1;
            checks++; if (dma_ack !== exp_ack) begin failures++; $display("FAIL burst_ack cyc=%0d got=%b exp=%b", i, dma_ack, exp_ack); end
            checks++; if (cpu_ready !== exp_ready) begin failures++; $display("FAIL burst_ready cyc=%0d got=%b exp=%b", i, cpu_ready, exp_ready); end
            if (!exp_ready) begin
                checks++; if (mem_addr !== dma_addr || mem_we !== exp_ack || io_we !== 1'b0) begin
                    failures++; $display("FAIL burst_stall_bus cyc=%0d got addr=%h we=%b exp addr=%h we=%b", i, mem_addr, mem_we, dma_addr, exp_ack);
                end
            end
            if (exp_ack) k++;
            step();
        end
        for (int j = 0; j < 6; j++) begin
            checks++; if (mem_arr[16'h4000 + 16'(j)] !== 8'h10 + 8'(j)) begin
                failures++; $display("FAIL burst_mem addr=%h got=%h exp=%h", 16'h4000 + 16'(j), mem_arr[16'h4000 + 16'(j)], 8'h10 + 8'(j));
            end
        end
        settle();
    endtask

    task automatic test_dma_read();
        cpu_address_next = 16'h1234;
        cpu_write_next   = 1'b1;
        cpu_data_o_next  = 8'h5a;
        step();
        idle();
        dma_req  = 1'b1;
        dma_addr = 16'h1234;
        #1;
        checks++; if (dma_ack !== 1'b0) begin failures++; $display("FAIL dmard_pre_ack got=%b exp=0", dma_ack); end
        step();
        #1;
        checks++; if (dma_ack !== 1'b1 || dma_rvalid !== 1'b0) begin failures++; $display("FAIL dmard_ack got ack=%b rvalid=%b exp ack=1 rvalid=0", dma_ack, dma_rvalid); end
        step();
        dma_req = 1'b0;
        #1;
        checks++; if (dma_rvalid !== 1'b1) begin failures++; $display("FAIL dmard_rvalid got=%b exp=1", dma_rvalid); end
        checks++; if (dma_rdata !== 8'h5a) begin failures++; $display("FAIL dmard_rdata got=%h exp=5a", dma_rdata); end
        checks++; if (cpu_ready !== 1'b0 || dma_ack !== 1'b0) begin failures++; $display("FAIL dmard_idle got ready=%b ack=%b exp ready=0 ack=0", cpu_ready, dma_ack); end
        step();
        #1;
        checks++; if (dma_rvalid !== 1'b0 || cpu_ready !== 1'b1) begin failures++; $display("FAIL dmard_after got rvalid=%b ready=%b exp rvalid=0 ready=1", dma_rvalid, cpu_ready); end
        settle();
    endtask

    task automatic test_stall_hold();
        cpu_address_next = 16'h0200;
        cpu_write_next   = 1'b1;
        cpu_data_o_next  = 8'ha9;
        step();
        cpu_write_next = 1'b0;
        dma_req   = 1'b1;
        dma_write = 1'b1;
        dma_addr  = 16'h0200;
        dma_wdata = 8'h00;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 2) dma_req = 1'b0;
            #1;
            checks++; if (cpu_data_i !== 8'ha9) begin failures++; $display("FAIL hold_data cyc=%0d got=%h exp=a9", i, cpu_data_i); end
            checks++; if (cpu_ready !== (i == 3)) begin failures++; $display("FAIL hold_ready cyc=%0d got=%b exp=%b", i, cpu_ready, (i == 3)); end
            step();
        end
        #1;
        checks++; if (cpu_data_i !== 8'h00) begin failures++; $display("FAIL hold_reread got=%h exp=00", cpu_data_i); end
        settle();
    endtask

    task automatic test_io();
        dma_req   = 1'b1;
        dma_write = 1'b1;
        dma_addr  = IO_ADDR;
        dma_wdata = 8'h77;
        step();
        #1;
        checks++; if (mem_we !== 1'b1 || io_we !== 1'b0 || mem_addr !== IO_ADDR) begin
            failures++; $display("FAIL io_dma_to_mem got we=%b io_we=%b addr=%h exp we=1 io_we=0 addr=%h", mem_we, io_we, mem_addr, IO_ADDR);
        end
        step();
        idle();
        step();
        cpu_address_next = IO_ADDR;
        cpu_write_next   = 1'b1;
        cpu_data_o_next  = 8'h3c;
        #1;
        checks++; if (io_we !== 1'b1) begin failures++; $display("FAIL io_we got=%b exp=1", io_we); end
        checks++; if (io_wdata !== 8'h3c) begin failures++; $display("FAIL io_wdata got=%h exp=3c", io_wdata); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL io_mem_we got=%b exp=0", mem_we); end
        step();
        cpu_write_next = 1'b0;
        io_rdata       = 8'h81;
        step();
        io_rdata         = 8'h00;
        cpu_address_next = 16'h0000;
        #1;
        checks++; if (cpu_data_i !== 8'h81) begin failures++; $display("FAIL io_rdata got=%h exp=81", cpu_data_i); end
        checks++; if (mem_arr[IO_ADDR] !== 8'h77) begin failures++; $display("FAIL io_mem_untouched got=%h exp=77", mem_arr[IO_ADDR]); end
        settle();
    endtask

    task automatic test_reset_mid_burst();
        dma_req   = 1'b1;
        dma_write = 1'b1;
        dma_addr  = 16'h4800;
        dma_wdata = 8'h55;
        step();
        step();
        #1;
        checks++; if (dma_ack !== 1'b1) begin failures++; $display("FAIL rstmid_second_ack got=%b exp=1", dma_ack); end
        reset = 1'b1;
        #1;
        checks++; if (dma_ack !== 1'b0 || cpu_ready !== 1'b1 || mem_we !== 1'b0) begin
            failures++; $display("FAIL rstmid_immediate got ack=%b ready=%b we=%b exp ack=0 ready=1 we=0", dma_ack, cpu_ready, mem_we);
        end
        step();
        reset = 1'b0;
        #1;
        checks++; if (cpu_ready !== 1'b1 || dma_ack !== 1'b0) begin failures++; $display("FAIL rstmid_cpu_owner got ready=%b ack=%b exp ready=1 ack=0", cpu_ready, dma_ack); end
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (dma_ack !== (i < 4) || cpu_ready !== (i == 4)) begin
                failures++; $display("FAIL rstmid_tenure cyc=%0d got ack=%b ready=%b exp ack=%b ready=%b", i, dma_ack, cpu_ready, (i < 4), (i == 4));
            end
            step();
        end
        settle();
    endtask

    task automatic test_random();
        logic [7:0] ref_mem [0:15];
        logic       m_dma;
        int         m_acks;
        logic       m_cpu_known;
        logic [7:0] m_cpu_data;
        logic       m_rvalid;
        logic [7:0] m_rdata;
        logic       e_we, e_io_we;
        logic [15:0] e_addr;
        logic [7:0]  e_di;
        int          run_len;
        for (int k = 0; k < 16; k++) begin
            ref_mem[k]       = 8'($urandom);
            cpu_address_next = 16'h0500 + 16'(k);
            cpu_write_next   = 1'b1;
            cpu_data_o_next  = ref_mem[k];
            step();
        end
        idle();
        step();
        m_dma = 1'b0; m_acks = 0; m_cpu_known = 1'b0; m_cpu_data = 8'h00;
        m_rvalid = 1'b0; m_rdata = 8'h00; run_len = 0;
        for (int c = 0; c < 400; c++) begin
            dma_req          = ($urandom_range(0, 3) != 0);
            dma_write        = 1'($urandom_range(0, 1));
            dma_addr         = 16'h0500 + 16'($urandom_range(0, 15));
            dma_wdata        = 8'($urandom);
            cpu_address_next = ($urandom_range(0, 7) == 0) ? IO_ADDR : 16'h0500 + 16'($urandom_range(0, 15));
            cpu_write_next   = 1'($urandom_range(0, 1));
            cpu_data_o_next  = 8'($urandom);
            io_rdata         = 8'($urandom);
            e_addr  = m_dma ? dma_addr : cpu_address_next;
            e_di    = m_dma ? dma_wdata : cpu_data_o_next;
            e_we    = m_dma ? (dma_req & dma_write) : (cpu_write_next & (cpu_address_next != IO_ADDR));
            e_io_we = !m_dma & cpu_write_next & (cpu_address_next == IO_ADDR);
            #1;
            checks++; if (cpu_ready !== !m_dma) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, cpu_ready, !m_dma); end
            checks++; if (dma_ack !== (m_dma & dma_req)) begin failures++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", c, dma_ack, m_dma & dma_req); end
            checks++; if (mem_we !== e_we || io_we !== e_io_we) begin failures++; $display("FAIL rnd_we cyc=%0d got we=%b io_we=%b exp we=%b io_we=%b", c, mem_we, io_we, e_we, e_io_we); end
            checks++; if (mem_addr !== e_addr) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, mem_addr, e_addr); end
            if (e_we) begin
                checks++; if (mem_di !== e_di) begin failures++; $display("FAIL rnd_di cyc=%0d got=%h exp=%h", c, mem_di, e_di); end
            end
            if (m_cpu_known) begin
                checks++; if (cpu_data_i !== m_cpu_data) begin failures++; $display("FAIL rnd_cpu_data cyc=%0d got=%h exp=%h", c, cpu_data_i, m_cpu_data); end
            end
            checks++; if (dma_rvalid !== m_rvalid) begin failures++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, dma_rvalid, m_rvalid); end
            if (m_rvalid) begin
                checks++; if (dma_rdata !== m_rdata) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, dma_rdata, m_rdata); end
            end
            // The CPU never waits through more than one full tenure of acks.
            run_len = cpu_ready ? 0 : run_len + 1;
            checks++; if (run_len > BURST_MAX + 1) begin failures++; $display("FAIL rnd_starve cyc=%0d got=%0d exp<=%0d", c, run_len, BURST_MAX + 1); end
            m_rvalid = 1'b0;
            if (!m_dma) begin
                m_cpu_known = 1'b1;
                if (cpu_address_next == IO_ADDR) begin
                    m_cpu_data = io_rdata;
                end else begin
                    m_cpu_data = ref_mem[cpu_address_next[3:0]];
                    if (cpu_write_next) ref_mem[cpu_address_next[3:0]] = cpu_data_o_next;
                end
                m_dma  = dma_req;
                m_acks = 0;
            end else if (!dma_req) begin
                m_dma = 1'b0;
            end else begin
                m_rvalid = !dma_write;
                m_rdata  = ref_mem[dma_addr[3:0]];
                if (dma_write) ref_mem[dma_addr[3:0]] = dma_wdata;
                m_acks++;
                if (m_acks == BURST_MAX) m_dma = 1'b0;
            end
            step();
        end
        for (int k = 0; k < 16; k++) begin
            checks++; if (mem_arr[16'h0500 + 16'(k)] !== ref_mem[k]) begin
                failures++; $display("FAIL rnd_mem addr=%h got=%h exp=%h", 16'h0500 + 16'(k), mem_arr[16'h0500 + 16'(k)], ref_mem[k]);
            end
        end
        settle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_no_dma();
        test_burst();
        test_dma_read();
        test_stall_hold();
        test_io();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
